// File: rtl/paddsub_simd_pipe_if.sv
// Operand and result handshake bundle for the packed SIMD add/subtract pipeline.
// The master drives operands and consumes results; the slave is the pipeline.
interface paddsub_simd_pipe_if #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*LANE_W-1:0]   a_in;
    logic [LANES*LANE_W-1:0]   b_in;
    logic [1:0]                op;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*LANE_W-1:0]   sum_out;
    logic [LANES-1:0]          ovf_out;

    modport master (
        output in_valid, a_in, b_in, op, out_ready,
        input  in_ready, out_valid, sum_out, ovf_out
    );

    modport slave (
        input  in_valid, a_in, b_in, op, out_ready,
        output in_ready, out_valid, sum_out, ovf_out
    );
endinterface

// File: rtl/paddsub_simd_pipe.sv
// Two-stage packed SIMD add/subtract with per-lane saturation or wrap,
// per-lane overflow flags and a sticky overflow history.
module paddsub_simd_pipe #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    paddsub_simd_pipe_if.slave    bus,
    input  logic                  clr_sticky,
    output logic [LANES-1:0]      ovf_sticky
);
    localparam int W = LANES * LANE_W;

    // Returns {overflow, lane result}; op[0] selects subtract, op[1] selects wrap.
    function automatic logic [LANE_W:0] lane_calc(
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b,
        input logic [1:0]        op
    );
        logic [LANE_W-1:0] b_eff;
        logic [LANE_W-1:0] raw;
        logic [LANE_W-1:0] res;
        logic              ovf;
        b_eff = op[0] ? ~b : b;
        raw   = a + b_eff + {{(LANE_W-1){1'b0}}, op[0]};
        // Comparing against ~b for subtraction folds both overflow rules into one test.
        ovf   = (a[LANE_W-1] == b_eff[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
        if (ovf && !op[1]) begin
            res = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
            res = raw;
        end
        return {ovf, res};
    endfunction

    logic             s1_valid_r;
    logic [W-1:0]     s1_a_r;
    logic [W-1:0]     s1_b_r;
    logic [1:0]       s1_op_r;
    logic             s2_valid_r;
    logic [W-1:0]     s2_sum_r;
    logic [LANES-1:0] s2_ovf_r;
    logic [LANES-1:0] sticky_r;

    logic             s2_take_s;
    logic             accept_s;
    logic             out_fire_s;
    logic [W-1:0]     s1_sum_s;
    logic [LANES-1:0] s1_ovf_s;
    logic [LANE_W:0]  lane_s;

    assign out_fire_s    = s2_valid_r & bus.out_ready;
    assign s2_take_s     = s1_valid_r & (~s2_valid_r | out_fire_s);
    assign bus.in_ready  = ~s1_valid_r | s2_take_s;
    assign accept_s      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = s2_valid_r;
    assign bus.sum_out   = s2_sum_r;
    assign bus.ovf_out   = s2_ovf_r;
    assign ovf_sticky    = sticky_r;

    // Per-lane arithmetic on the registered S1 operands.
    always_comb begin
        s1_sum_s = {W{1'b0}};
        s1_ovf_s = {LANES{1'b0}};
        lane_s   = {(LANE_W+1){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            lane_s = lane_calc(s1_a_r[i*LANE_W +: LANE_W], s1_b_r[i*LANE_W +: LANE_W], s1_op_r);
            s1_sum_s[i*LANE_W +: LANE_W] = lane_s[LANE_W-1:0];
            s1_ovf_s[i]                  = lane_s[LANE_W];
        end
    end

    // Stage 1: operand capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
            s1_op_r    <= 2'b00;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= bus.a_in;
            s1_b_r     <= bus.b_in;
            s1_op_r    <= bus.op;
        end else if (s2_take_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: result register; data is left untouched after it drains so stalls stay stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sum_r   <= {W{1'b0}};
            s2_ovf_r   <= {LANES{1'b0}};
        end else if (s2_take_s) begin
            s2_valid_r <= 1'b1;
            s2_sum_r   <= s1_sum_s;
            s2_ovf_r   <= s1_ovf_s;
        end else if (out_fire_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Sticky history: fresh overflow on a delivered result survives a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= {LANES{1'b0}};
        end else if (out_fire_s) begin
            sticky_r <= (clr_sticky ? {LANES{1'b0}} : sticky_r) | s2_ovf_r;
        end else if (clr_sticky) begin
            sticky_r <= {LANES{1'b0}};
        end
    end
endmodule

// File: tb/tb_paddsub_simd_pipe.sv
// Directed plus randomized bench for paddsub_simd_pipe with an arithmetic reference model.
module tb_paddsub_simd_pipe;
    localparam int LW   = 4;
    localparam int LN   = 4;
    localparam int W    = LW * LN;
    localparam int MAXV = (1 << (LW - 1)) - 1;
    localparam int MINV = -(1 << (LW - 1));

    typedef struct packed {
        logic [W-1:0]  sum;
        logic [LN-1:0] ovf;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          clr_sticky;
    logic [LN-1:0] ovf_sticky;

    paddsub_simd_pipe_if #(.LANE_W(LW), .LANES(LN)) bus ();

    paddsub_simd_pipe #(.LANE_W(LW), .LANES(LN)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            errors   = 0;
    int            checks   = 0;
    int            accepted = 0;
    int            fired    = 0;
    exp_t          exp_q[$];
    logic [LN-1:0] sticky_m = '0;
    logic [W-1:0]  last_sum = '0;
    logic [LN-1:0] last_ovf = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: signed integer arithmetic per lane, then clamp or wrap.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        exp_t r;
        int av, bv, s, v;
        logic [LW-1:0] la, lb;
        r = '0;
        for (int i = 0; i < LN; i++) begin
            la = a[i*LW +: LW];
            lb = b[i*LW +: LW];
            av = $signed(la);
            bv = $signed(lb);
            s  = op[0] ? av - bv : av + bv;
            r.ovf[i] = (s > MAXV) || (s < MINV);
            v = s;
            if (r.ovf[i] && !op[1]) v = (s > MAXV) ? MAXV : MINV;
            r.sum[i*LW +: LW] = v[LW-1:0];
        end
        return r;
    endfunction

    // One clock: record transfers decided by the current inputs, advance, check sticky.
    task automatic tick();
        exp_t e;
        logic acc;
        #1;
        acc = bus.in_valid & bus.in_ready;
        if (rst) begin
            exp_q.delete();
            sticky_m = '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                    e = '0;
                end else begin
                    e = exp_q.pop_front();
                    check("sum_out", bus.sum_out, e.sum);
                    check("ovf_out", bus.ovf_out, e.ovf);
                end
                sticky_m = (clr_sticky ? '0 : sticky_m) | e.ovf;
                last_sum = bus.sum_out;
                last_ovf = bus.ovf_out;
                fired++;
            end else if (clr_sticky) begin
                sticky_m = '0;
            end
            if (acc) begin
                exp_q.push_back(model(bus.a_in, bus.b_in, bus.op));
                accepted++;
            end
        end
        @(posedge clk);
        #1;
        check("ovf_sticky", ovf_sticky, sticky_m);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] es, input logic [LN-1:0] eo, input string tag);
        int n0;
        n0 = fired;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a_in = a; bus.b_in = b; bus.op = op;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 6 && fired == n0; k++) tick();
        check({tag, "_done"}, 32'(fired > n0), 32'd1);
        check({tag, "_sum"}, last_sum, es);
        check({tag, "_ovf"}, last_ovf, eo);
    endtask

    initial begin
        logic [W-1:0] held;
        int a0, f0;
        rst = 1'b1; clr_sticky = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a_in = '0; bus.b_in = '0; bus.op = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_sum", bus.sum_out, 32'd0);
        check("rst_ovf", bus.ovf_out, 32'd0);
        check("rst_sticky", ovf_sticky, 32'd0);
        check("rst_in_ready", bus.in_ready, 32'd1);
        rst = 1'b0;

        send(16'h7321, 16'h1111, 2'b00, 16'h7432, 4'b1000, "addsat");
        send(16'h8000, 16'h1000, 2'b01, 16'h8000, 4'b1000, "subsat_neg");
        send(16'h0700, 16'h0900, 2'b01, 16'h0700, 4'b0100, "subsat_pos");
        send(16'h7000, 16'h1000, 2'b10, 16'h8000, 4'b1000, "addwrap");
        send(16'h7000, 16'h1000, 2'b11, 16'h6000, 4'b0000, "subwrap");

        // Backpressure: three sets offered while the consumer stalls.
        bus.out_ready = 1'b0;
        a0 = accepted;
        bus.in_valid = 1'b1;
        bus.a_in = 16'h1234; bus.b_in = 16'h1111; bus.op = 2'b00; tick();
        bus.a_in = 16'h2345; bus.b_in = 16'h0101; bus.op = 2'b01; tick();
        bus.a_in = 16'h7777; bus.b_in = 16'h7777; bus.op = 2'b10;
        held = bus.sum_out;
        tick(); tick(); tick();
        check("bp_accepted", accepted - a0, 32'd2);
        check("bp_in_ready", bus.in_ready, 32'd0);
        check("bp_out_valid", bus.out_valid, 32'd1);
        check("bp_held", bus.sum_out, held);
        f0 = fired;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bp_third_accepted", accepted - a0, 32'd3);
        tick(); tick();
        check("bp_emerged", fired - f0, 32'd3);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_in = 16'h7777; bus.b_in = 16'h1111; bus.op = 2'b00; tick();
        bus.a_in = 16'h8888; bus.b_in = 16'h1111; bus.op = 2'b01; tick();
        check("pre_rst_full", bus.out_valid & ~bus.in_ready, 32'd1);
        rst = 1'b1; bus.out_ready = 1'b1; clr_sticky = 1'b0;
        tick();
        rst = 1'b0; bus.in_valid = 1'b0;
        check("midrst_out_valid", bus.out_valid, 32'd0);
        check("midrst_sticky", ovf_sticky, 32'd0);
        check("midrst_in_ready", bus.in_ready, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_stale", bus.out_valid, 32'd0);
        end

        // Sticky: lane-3 overflow, then clear coincident with a lane-0 overflow handshake.
        send(16'h7000, 16'h1000, 2'b00, 16'h7000, 4'b1000, "stk_l3");
        check("stk_l3_sticky", ovf_sticky, 32'h8);
        bus.in_valid = 1'b1;
        bus.a_in = 16'h0007; bus.b_in = 16'h0001; bus.op = 2'b00;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 6 && !bus.out_valid; k++) tick();
        check("stk_wait", bus.out_valid, 32'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("stk_coincident", ovf_sticky, 32'h1);
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        check("stk_cleared", ovf_sticky, 32'h0);

        // Randomized traffic against the scoreboard.
        for (int n = 0; n < 300; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr_sticky    = ($urandom_range(0, 15) == 0);
            bus.a_in = W'($urandom);
            bus.b_in = W'($urandom);
            bus.op   = 2'($urandom_range(0, 3));
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; clr_sticky = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        check("drain_empty", exp_q.size(), 32'd0);
        check("drain_out_valid", bus.out_valid, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
